keypad_scan_debounce: RTL
=========================

KEYPAD_SCAN_DEBOUNCE -- requirements
Module: keypad_scan_debounce

Interface
REQ-001 Parameter N_ROWS, 4, number of driven rows (2..8).
REQ-002 Parameter N_COLS, 4, number of sensed columns (2..8).
REQ-003 Parameter SCAN_DIV, 1000, clk cycles each row is driven before its columns are sampled (>=2).
REQ-004 Parameter DB_CYCLES, 50000, consecutive stable clk cycles required for press or release acceptance (>=2).
REQ-005 Parameter REPEAT_CYCLES, 12000000, hold time between auto-repeat pulses (used only with the Configuration macro).
REQ-006 clk  input  1  system clock; all state is updated on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 col  input  N_COLS  raw column sense lines, active-high, asynchronous to clk.
REQ-009 r_sel  output  N_ROWS  one-hot row drive, active-high.
REQ-010 key_code  output  clog2(N_ROWS*N_COLS)  accepted key index = row*N_COLS + col index.
REQ-011 key_valid  output  1  one-cycle pulse per accepted key event.
REQ-012 key_held  output  1  high from acceptance until release is accepted.

Function
REQ-013 col SHALL pass through a 2-flop synchronizer; all logic below uses the synchronized value (colS).
REQ-014 FSM states SHALL be SCAN, PRESS_DB, HELD, RELEASE_DB.
REQ-015 SCAN: a dwell counter runs 0..SCAN_DIV-1; at terminal count, if colS==0, r_sel SHALL rotate to the next row (row N_ROWS-1 wraps to row 0) and the dwell counter SHALL restart.
REQ-016 SCAN, terminal count with colS!=0: SHALL latch row index and the lowest-index set colS bit (lowest index wins on multiple columns), freeze r_sel, and enter PRESS_DB.
REQ-017 PRESS_DB: a counter SHALL increment each cycle the latched column bit of colS is 1; a cycle with it 0 SHALL return to SCAN with r_sel advanced one row and no output event.
REQ-018 PRESS_DB: when the counter reaches DB_CYCLES-1, the next cycle SHALL enter HELD, load key_code, and assert key_valid for exactly one cycle.
REQ-019 key_code SHALL be stable from the key_valid cycle until the next key_valid; it SHALL NOT change in any other cycle.
REQ-020 HELD: key_held=1; r_sel frozen; other columns ignored; latched bit of colS going 0 SHALL enter RELEASE_DB with the counter cleared.
REQ-021 RELEASE_DB: counter increments each cycle the latched bit is 0; latched bit returning to 1 SHALL return to HELD with no key_valid; reaching DB_CYCLES-1 SHALL enter SCAN, deassert key_held, and advance r_sel one row.
REQ-022 Every debounce and dwell count SHALL be sized clog2 of its terminal value and SHALL NOT wrap within a state.
REQ-023 r_sel SHALL be one-hot in every cycle, including reset.
REQ-024 A second key pressed while HELD SHALL produce no event; it SHALL be detected only after the first release completes and scanning reaches its row.

Reset
REQ-025 reset low SHALL immediately force state SCAN, r_sel=row 0 (bit 0 set), key_valid=0, key_held=0, key_code=0, all counters and synchronizer flops 0.
REQ-026 reset asserted mid-debounce or mid-hold SHALL discard the pending key with no key_valid emitted after release of reset.
REQ-027 Scanning SHALL begin on the first clk edge after reset deasserts.

Configuration
REQ-028 Macro KEYPAD_AUTOREPEAT_EN: when defined, a repeat counter SHALL run in HELD and re-pulse key_valid (same key_code) every REPEAT_CYCLES cycles held; it SHALL clear on entering HELD, on RELEASE_DB, and on reset, and SHALL pause (not clear) in RELEASE_DB bounces back to HELD.
REQ-029 When KEYPAD_AUTOREPEAT_EN is undefined, no repeat logic SHALL exist and exactly one key_valid SHALL be issued per accepted press.

Verification (N_ROWS=4, N_COLS=4, SCAN_DIV=4, DB_CYCLES=8, REPEAT_CYCLES=32)
REQ-030 Hold col=4'b0100 only while r_sel=4'b0010, for 20 cycles -> one key_valid, key_code=6, key_held=1 until release debounced.
REQ-031 Press with 3-cycle glitch (col low mid PRESS_DB) -> no key_valid; r_sel advances to next row.
REQ-032 Release bounce (col low 3 cycles, high again) while HELD -> key_held stays 1, no second key_valid.
REQ-033 col=4'b1010 on row 3 -> key_code=13 (column 1 wins).
REQ-034 reset low for 1 cycle during PRESS_DB -> r_sel=4'b0001, key_valid never pulses for that press.
REQ-035 KEYPAD_AUTOREPEAT_EN defined, key held 100 cycles after acceptance -> key_valid pulses at acceptance and every 32 cycles (4 total); undefined -> 1 pulse.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
// Purpose: matrix keypad scanner; rotates a one-hot row drive and debounces the first key it finds.
// Latency: 2-cycle column synchronizer, then key_valid DB_CYCLES cycles after the scan latches a press.
// Backpressure: none; key_valid is a single-cycle pulse and key_code holds until the next key_valid.
// Optional KEYPAD_AUTOREPEAT_EN: re-pulse key_valid every REPEAT_CYCLES cycles while the key stays held.
module keypad_scan_debounce #(
    parameter int N_ROWS        = 4,
    parameter int N_COLS        = 4,
    parameter int SCAN_DIV      = 1000,
    parameter int DB_CYCLES     = 50000,
    parameter int REPEAT_CYCLES = 12000000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [N_COLS-1:0]                 col,
    output logic [N_ROWS-1:0]                 r_sel,
    output logic [$clog2(N_ROWS*N_COLS)-1:0]  key_code,
    output logic                              key_valid,
    output logic                              key_held
);

    localparam int KW = $clog2(N_ROWS * N_COLS);
    localparam int RW = $clog2(N_ROWS);
    localparam int CW = $clog2(N_COLS);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DB_CYCLES);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DB_CYCLES - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N_ROWS - 1);
    localparam logic [KW-1:0] NC_K       = KW'(N_COLS);

    // Parameter values the counters and index fields cannot represent stop elaboration.
    if (N_ROWS < 2 || N_ROWS > 8 || N_COLS < 2 || N_COLS > 8 ||
        SCAN_DIV < 2 || DB_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
        $error("keypad_scan_debounce: parameter out of range");
    end

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [N_COLS-1:0]   col_meta_q, col_meta_d;
    logic [N_COLS-1:0]   col_s_q, col_s_d;
    logic [DW-1:0]       dwell_q, dwell_d;
    logic [BW-1:0]       db_q, db_d;
    logic [RW-1:0]       row_q, row_d;
    logic [N_ROWS-1:0]   r_sel_q, r_sel_d;
    logic [CW-1:0]       col_idx_q, col_idx_d;
    logic [KW-1:0]       key_code_q, key_code_d;
    logic                key_valid_q, key_valid_d;
    logic                key_held_q, key_held_d;

    logic [CW-1:0]       low_col;
    logic                col_bit;
    logic [RW-1:0]       row_next;
    logic [KW-1:0]       key_idx;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int PW = $clog2(REPEAT_CYCLES);
    localparam logic [PW-1:0] REP_LAST = PW'(REPEAT_CYCLES - 1);
    logic [PW-1:0]       rep_q, rep_d;
`endif

    // The latched column bit is the only sense line that matters once a key is being debounced.
    assign col_bit  = col_s_q[col_idx_q];
    assign row_next = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    assign key_idx  = KW'(row_q) * NC_K + KW'(col_idx_q);

    // Pick the lowest-index active column so simultaneous presses on one row resolve deterministically.
    always_comb begin
        low_col = '0;
        for (int i = N_COLS - 1; i >= 0; i--) begin
            if (col_s_q[i]) begin
                low_col = CW'(i);
            end
        end
    end

    // Scan / debounce state machine: next-state and registered-output values.
    always_comb begin
        col_meta_d  = col;
        col_s_d     = col_meta_q;
        state_d     = state_q;
        dwell_d     = dwell_q;
        db_d        = db_q;
        row_d       = row_q;
        col_idx_d   = col_idx_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d       = rep_q;
`endif
        case (state_q)
            SCAN: begin
                if (dwell_q != DWELL_LAST) begin
                    dwell_d = dwell_q + 1'b1;
                end else if (col_s_q == '0) begin
                    row_d   = row_next;
                    dwell_d = '0;
                end else begin
                    state_d   = PRESS_DB;
                    col_idx_d = low_col;
                    db_d      = '0;
                    dwell_d   = '0;
                end
            end
            PRESS_DB: begin
                if (!col_bit) begin
                    // Glitch: abandon this key and move on rather than rescanning the same row.
                    state_d = SCAN;
                    row_d   = row_next;
                    dwell_d = '0;
                end else if (db_q == DB_LAST) begin
                    state_d     = HELD;
                    key_code_d  = key_idx;
                    key_valid_d = 1'b1;
                    key_held_d  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d       = '0;
`endif
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            HELD: begin
                if (!col_bit) begin
                    state_d = RELEASE_DB;
                    db_d    = '0;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (rep_q == REP_LAST) begin
                    key_valid_d = 1'b1;
                    rep_d       = '0;
                end else begin
                    rep_d = rep_q + 1'b1;
                end
`endif
            end
            RELEASE_DB: begin
                if (col_bit) begin
                    // Release bounce: resume holding; any repeat count simply resumes.
                    state_d = HELD;
                end else if (db_q == DB_LAST) begin
                    state_d    = SCAN;
                    key_held_d = 1'b0;
                    row_d      = row_next;
                    dwell_d    = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                    rep_d      = '0;
`endif
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    // Row drive is rebuilt from the next row index so it is one-hot by construction.
    always_comb begin
        r_sel_d        = '0;
        r_sel_d[row_d] = 1'b1;
    end

    // State, synchronizer and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            col_meta_q  <= '0;
            col_s_q     <= '0;
            dwell_q     <= '0;
            db_q        <= '0;
            row_q       <= '0;
            r_sel_q     <= {{(N_ROWS-1){1'b0}}, 1'b1};
            col_idx_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            col_meta_q  <= col_meta_d;
            col_s_q     <= col_s_d;
            dwell_q     <= dwell_d;
            db_q        <= db_d;
            row_q       <= row_d;
            r_sel_q     <= r_sel_d;
            col_idx_q   <= col_idx_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign r_sel     = r_sel_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule
